// File: rtl/relin_pkg.sv
// Shared definitions for the relinearisation datapath: default sizes and the
// tile queue state encoding.
package relin_pkg;

    localparam int RELIN_DATA_WIDTH    = 64;
    localparam int RELIN_C2_TILE_WIDTH = 8;
    localparam int RELIN_C2_WIDTH      = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        SERVE_C0 = 2'd2,
        SERVE_C1 = 2'd3
    } c2q_state_e;

endpackage

// File: rtl/c2_tile_mem.sv
// Tile storage for the c2 queue: NUM_TILES tile registers with one synchronous
// write port and one asynchronous read port. Contents are never reset.
module c2_tile_mem #(
    parameter int DATA_WIDTH    = 64,
    parameter int C2_TILE_WIDTH = 8,
    parameter int NUM_TILES     = 8,
    parameter int PTR_W         = $clog2(NUM_TILES)
) (
    input  logic                                         clk,
    input  logic                                         we_i,
    input  logic [PTR_W-1:0]                             waddr_i,
    input  logic [C2_TILE_WIDTH-1:0][DATA_WIDTH-1:0]     wdata_i,
    input  logic [PTR_W-1:0]                             raddr_i,
    output logic [C2_TILE_WIDTH-1:0][DATA_WIDTH-1:0]     rdata_o
);

    logic [C2_TILE_WIDTH-1:0][DATA_WIDTH-1:0] mem_q [NUM_TILES];

    // Store the incoming tile at the write pointer; no reset on the array.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/c2_tile_queue.sv
// Collects one c2 polynomial as NUM_TILES tiles, then replays the stored tiles
// twice to the relin unit: first as the c0 pass, then as the c1 pass.
module c2_tile_queue
    import relin_pkg::*;
#(
    parameter int DATA_WIDTH    = RELIN_DATA_WIDTH,
    parameter int C2_TILE_WIDTH = RELIN_C2_TILE_WIDTH,
    parameter int C2_WIDTH      = RELIN_C2_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic                                     in_valid,
    input  logic [C2_TILE_WIDTH-1:0][DATA_WIDTH-1:0] in_tile,
    output logic                                     in_ready,
    input  logic                                     dequeue,
    output logic [C2_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_out,
    output logic                                     tile_valid,
    output logic                                     c1_or_c0,
    output logic                                     poly_done
);

    localparam int NUM_TILES = C2_WIDTH / C2_TILE_WIDTH;
    localparam int PTR_W     = $clog2(NUM_TILES);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_TILES - 1);

    c2q_state_e       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             done_q, done_d;
    logic             wr_fire;
    logic             pop;

    assign in_ready   = (state_q == IDLE) || (state_q == FILL);
    assign tile_valid = (state_q == SERVE_C0) || (state_q == SERVE_C1);
    assign c1_or_c0   = (state_q == SERVE_C1);
    assign poly_done  = done_q;

    assign wr_fire = in_valid && in_ready;
    assign pop     = dequeue && tile_valid;

    c2_tile_mem #(
        .DATA_WIDTH    (DATA_WIDTH),
        .C2_TILE_WIDTH (C2_TILE_WIDTH),
        .NUM_TILES     (NUM_TILES),
        .PTR_W         (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_fire && !flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_tile),
        .raddr_i (rd_ptr_q),
        .rdata_o (tile_out)
    );

    // State, pointers and the done pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: fill until the last tile lands, then two replay passes.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        done_d   = 1'b0;
        if (flush) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            unique case (state_q)
                IDLE, FILL: begin
                    if (wr_fire) begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        state_d  = (wr_ptr_q == LAST_IDX) ? SERVE_C0 : FILL;
                    end
                end
                SERVE_C0: begin
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        if (rd_ptr_q == LAST_IDX) begin
                            state_d = SERVE_C1;
                        end
                    end
                end
                SERVE_C1: begin
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        if (rd_ptr_q == LAST_IDX) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c2_tile_queue.sv
// Directed bench for c2_tile_queue with NUM_TILES = 8.
module tb_c2_tile_queue;

    typedef logic [7:0][63:0] tile_t;

    logic  clk = 1'b0;
    logic  rst, flush, in_valid, dequeue;
    tile_t in_tile;
    logic  in_ready;
    tile_t tile_out;
    logic  tile_valid, c1_or_c0, poly_done;

    int total  = 0;
    int passed = 0;

    c2_tile_queue #(
        .DATA_WIDTH    (64),
        .C2_TILE_WIDTH (8),
        .C2_WIDTH      (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_tile    (in_tile),
        .in_ready   (in_ready),
        .dequeue    (dequeue),
        .tile_out   (tile_out),
        .tile_valid (tile_valid),
        .c1_or_c0   (c1_or_c0),
        .poly_done  (poly_done)
    );

    always #5 clk = ~clk;

    function automatic tile_t mk(input int t, input int ofs);
        tile_t r;
        for (int l = 0; l < 8; l++) begin
            r[l] = 64'(ofs) * 64'h10000 + 64'(t * 8 + l);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Eight back-to-back writes; deq_during drives dequeue while filling.
    task automatic fill(input int ofs, input logic deq_during);
        dequeue = deq_during;
        for (int t = 0; t < 8; t++) begin
            in_valid = 1'b1;
            in_tile  = mk(t, ofs);
            chk($sformatf("fill_ready_%0d", t), 512'(in_ready), 512'(1));
            chk($sformatf("fill_novalid_%0d", t), 512'(tile_valid), 512'(0));
            chk($sformatf("fill_nodone_%0d", t), 512'(poly_done), 512'(0));
            step();
        end
        in_valid = 1'b0;
        dequeue  = 1'b0;
    endtask

    // Both replay passes with a pop every cycle, ending with the done pulse.
    task automatic serve_full(input int ofs, input logic drop_valid);
        for (int p = 0; p < 2; p++) begin
            for (int t = 0; t < 8; t++) begin
                chk($sformatf("srv_valid_p%0d_t%0d", p, t), 512'(tile_valid), 512'(1));
                chk($sformatf("srv_sel_p%0d_t%0d", p, t), 512'(c1_or_c0), 512'(p));
                chk($sformatf("srv_data_p%0d_t%0d", p, t), tile_out, mk(t, ofs));
                chk($sformatf("srv_nodone_p%0d_t%0d", p, t), 512'(poly_done), 512'(0));
                if (drop_valid) chk("bp_ready", 512'(in_ready), 512'(0));
                dequeue = 1'b1;
                step();
            end
        end
        dequeue = 1'b0;
        if (drop_valid) in_valid = 1'b0;
        chk("done_pulse", 512'(poly_done), 512'(1));
        chk("done_idle_valid", 512'(tile_valid), 512'(0));
        chk("done_idle_ready", 512'(in_ready), 512'(1));
        step();
        chk("done_clear", 512'(poly_done), 512'(0));
    endtask

    initial begin
        tile_t hold;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; dequeue = 1'b0; in_tile = '0;
        step();
        chk("rst_valid", 512'(tile_valid), 512'(0));
        chk("rst_sel", 512'(c1_or_c0), 512'(0));
        chk("rst_done", 512'(poly_done), 512'(0));
        chk("rst_ready", 512'(in_ready), 512'(1));
        rst = 1'b0;
        step();

        // Dequeue in IDLE is ignored.
        dequeue = 1'b1;
        step(); step();
        chk("idle_deq_valid", 512'(tile_valid), 512'(0));
        chk("idle_deq_done", 512'(poly_done), 512'(0));
        dequeue = 1'b0;

        // Basic fill (with dequeue held during fill) then two passes from tile 0.
        fill(1, 1'b1);
        serve_full(1, 1'b0);

        // Backpressure: new data held on in_valid throughout serving.
        fill(2, 1'b0);
        in_valid = 1'b1;
        in_tile  = mk(5, 99);
        serve_full(2, 1'b1);

        // Sparse dequeue: pop every third cycle.
        fill(3, 1'b0);
        for (int k = 0; k < 16; k++) begin
            hold = mk(k % 8, 3);
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("sp_hold_%0d_%0d", k, g), tile_out, hold);
                chk($sformatf("sp_sel_%0d_%0d", k, g), 512'(c1_or_c0), 512'(k >= 8));
                step();
            end
            chk($sformatf("sp_pop_data_%0d", k), tile_out, hold);
            dequeue = 1'b1;
            step();
            dequeue = 1'b0;
        end
        chk("sp_done", 512'(poly_done), 512'(1));
        step();
        chk("sp_done_clear", 512'(poly_done), 512'(0));

        // Flush at SERVE_C1 tile 3.
        fill(4, 1'b0);
        dequeue = 1'b1;
        for (int k = 0; k < 11; k++) step();
        chk("fl_pre_sel", 512'(c1_or_c0), 512'(1));
        chk("fl_pre_data", tile_out, mk(3, 4));
        flush = 1'b1;
        step();
        flush = 1'b0;
        dequeue = 1'b0;
        chk("fl_valid", 512'(tile_valid), 512'(0));
        chk("fl_ready", 512'(in_ready), 512'(1));
        chk("fl_done", 512'(poly_done), 512'(0));
        fill(5, 1'b0);
        serve_full(5, 1'b0);

        // Asynchronous reset mid-fill after five writes.
        in_valid = 1'b1;
        for (int t = 0; t < 5; t++) begin
            in_tile = mk(t, 6);
            step();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 512'(tile_valid), 512'(0));
        chk("arst_ready", 512'(in_ready), 512'(1));
        chk("arst_sel", 512'(c1_or_c0), 512'(0));
        chk("arst_done", 512'(poly_done), 512'(0));
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        for (int t = 0; t < 7; t++) begin
            in_tile = mk(t, 7);
            step();
        end
        in_valid = 1'b0;
        chk("arst_7_valid", 512'(tile_valid), 512'(0));
        in_valid = 1'b1;
        in_tile  = mk(7, 7);
        step();
        in_valid = 1'b0;
        serve_full(7, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
